burst_rr_scheduler: RTL and testbench



---
 rtl/burst_rr_pkg.sv | 18 +
 rtl/rr_pick.sv | 40 ++++
 rtl/burst_rr_scheduler.sv | 113 +++++++++++
 tb/tb_burst_rr_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/burst_rr_pkg.sv
// Shared types and default sizes for the burst round-robin scheduler.
//   state_t     : scheduler FSM state (IDLE arbitrates, BURST transfers beats)
//   N_DEF       : default requester count
//   DW_DEF      : default beat data width
//   LENW_DEF    : default burst length field width (field = beats-1)
package burst_rr_pkg;

  localparam int unsigned N_DEF    = 3;
  localparam int unsigned DW_DEF   = 8;
  localparam int unsigned LENW_DEF = 4;
  localparam int unsigned SRCW_DEF = $clog2(N_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req      in  N     request vector
//   last_ptr in  SRCW  index of the previous winner (scan starts just past it)
//   found    out 1     at least one request is set
//   idx      out SRCW  first set request after last_ptr, wrapping modulo N
module rr_pick
  import burst_rr_pkg::*;
#(
  parameter  int unsigned N    = N_DEF,
  localparam int unsigned SRCW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SRCW-1:0] last_ptr,
  output logic            found,
  output logic [SRCW-1:0] idx
);

  localparam int unsigned PW = SRCW + 1;

  logic [2*N-1:0] dbl;
  logic [PW-1:0]  pos;

  // Duplicating the request vector turns the modulo-N wrap into a straight
  // scan over positions last_ptr+1 .. last_ptr+N. Scanning from the far end
  // lets the nearest set position overwrite the result.
  always_comb begin
    dbl   = {req, req};
    pos   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = int'(N); k >= 1; k--) begin
      pos = PW'(last_ptr) + PW'(k);
      if (dbl[pos]) begin
        found = 1'b1;
        idx   = (pos >= PW'(N)) ? SRCW'(pos - PW'(N)) : SRCW'(pos);
      end
    end
  end

endmodule

// File: rtl/burst_rr_scheduler.sv
// Round-robin scheduler with burst locking in front of a single beat port.
//   clk, rstn  clock, synchronous active-low reset
//   en         allows new grants (an ongoing burst always completes)
//   req_vld    per-requester beat valid / burst request
//   req_len    per-requester burst length-1, slice i = [i*LENW +: LENW]
//   req_data   per-requester beat data, slice i = [i*DW +: DW]
//   req_rdy    per-requester beat accepted
//   o_vld, o_data, o_last, o_src, o_rdy  downstream beat port
// Downstream outputs are steered combinationally from the granted requester.
module burst_rr_scheduler
  import burst_rr_pkg::*;
#(
  parameter  int unsigned N    = N_DEF,
  parameter  int unsigned DW   = DW_DEF,
  parameter  int unsigned LENW = LENW_DEF,
  localparam int unsigned SRCW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [N-1:0]      req_vld,
  input  logic [N*LENW-1:0] req_len,
  input  logic [N*DW-1:0]   req_data,
  output logic [N-1:0]      req_rdy,
  output logic              o_vld,
  output logic [DW-1:0]     o_data,
  output logic              o_last,
  output logic [SRCW-1:0]   o_src,
  input  logic              o_rdy
);

  state_t            state_q, state_d;
  logic [SRCW-1:0]   src_q, src_d;
  logic [LENW-1:0]   cnt_q, cnt_d;
  logic [SRCW-1:0]   last_q, last_d;

  logic              pick_found;
  logic [SRCW-1:0]   pick_idx;

  logic [LENW-1:0]   len_a  [N];
  logic [DW-1:0]     data_a [N];

  // Unpack the flat per-requester buses.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      len_a[i]  = req_len[i*LENW +: LENW];
      data_a[i] = req_data[i*DW +: DW];
    end
  end

  rr_pick #(.N(N)) u_pick (
    .req      (req_vld),
    .last_ptr (last_q),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  // State register; last_q resets to N-1 so requester 0 is first in line.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      src_q   <= '0;
      cnt_q   <= '0;
      last_q  <= SRCW'(N - 1);
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Next state and beat steering.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    o_vld   = 1'b0;
    o_data  = '0;
    o_last  = 1'b0;
    req_rdy = '0;

    case (state_q)
      IDLE: begin
        // Length is captured here only; later changes on req_len are ignored.
        if (en && pick_found) begin
          state_d = BURST;
          src_d   = pick_idx;
          cnt_d   = len_a[pick_idx];
        end
      end
      BURST: begin
        o_vld          = req_vld[src_q];
        o_data         = data_a[src_q];
        o_last         = (cnt_q == '0);
        req_rdy[src_q] = o_rdy;
        if (o_vld && o_rdy) begin
          if (o_last) begin
            last_d  = src_q;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - LENW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_src = src_q;

endmodule

// File: tb/tb_burst_rr_scheduler.sv
// Self-checking bench for burst_rr_scheduler (N=3, DW=8, LENW=4).
module tb_burst_rr_scheduler;
  import burst_rr_pkg::*;

  localparam int unsigned N    = 3;
  localparam int unsigned DW   = 8;
  localparam int unsigned LENW = 4;
  localparam int unsigned SRCW = $clog2(N);

  logic              clk = 1'b0;
  logic              rstn;
  logic              en;
  logic [N-1:0]      req_vld;
  logic [N*LENW-1:0] req_len;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_rdy;
  logic              o_vld;
  logic [DW-1:0]     o_data;
  logic              o_last;
  logic [SRCW-1:0]   o_src;
  logic              o_rdy;

  burst_rr_scheduler #(.N(N), .DW(DW), .LENW(LENW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .req_vld  (req_vld),
    .req_len  (req_len),
    .req_data (req_data),
    .req_rdy  (req_rdy),
    .o_vld    (o_vld),
    .o_data   (o_data),
    .o_last   (o_last),
    .o_src    (o_src),
    .o_rdy    (o_rdy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model: who owns the port, how many beats remain, who won last.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_left  = 0;
  int m_last  = int'(N) - 1;

  // Sources seen on accepted beats.
  int log_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  task automatic check_model();
    logic         e_vld, e_last;
    logic [N-1:0] e_rdy;
    e_vld  = m_busy ? req_vld[m_owner] : 1'b0;
    e_last = m_busy && (m_left == 1);
    e_rdy  = '0;
    if (m_busy) e_rdy[m_owner] = o_rdy;
    check("model_ctl", 32'({o_vld, o_last, req_rdy, o_src}),
          32'({e_vld, e_last, e_rdy, SRCW'(m_owner)}));
    if (m_busy) check("model_data", 32'(o_data), 32'(req_data[m_owner*DW +: DW]));
  endtask

  // Advance the model by the rules: reset, beat accounting, or round-robin grant.
  task automatic model_update();
    if (!rstn) begin
      m_busy = 1'b0; m_owner = 0; m_left = 0; m_last = int'(N) - 1;
    end else if (m_busy) begin
      if (req_vld[m_owner] && o_rdy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_last = m_owner;
        end
      end
    end else if (en) begin
      for (int k = 1; k <= int'(N); k++) begin
        int c;
        c = (m_last + k) % int'(N);
        if (req_vld[c]) begin
          m_busy  = 1'b1;
          m_owner = c;
          m_left  = int'(req_len[c*LENW +: LENW]) + 1;
          break;
        end
      end
    end
  endtask

  task automatic sample_and_advance();
    check_model();
    if (rstn && o_vld && o_rdy) log_q.push_back(int'(o_src));
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    #2;
    sample_and_advance();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_log(input string name, input int n, input int e [8]);
    check({name, "_count"}, 32'(log_q.size()), 32'(n));
    for (int i = 0; i < n && i < log_q.size(); i++) check(name, 32'(log_q[i]), 32'(e[i]));
  endtask

  typedef struct packed {
    logic              rstn;
    logic              en;
    logic [N-1:0]      vld;
    logic [N*LENW-1:0] len;
    logic              rdy;
    logic              e_vld;
    logic              e_last;
    logic [N-1:0]      e_rdy;
    logic [SRCW-1:0]   e_src;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  initial begin
    // Reset, req0 4-beat burst, then req1 3-beat burst under o_rdy 1,0,0,1,1.
    vecs[0]  = '{1'b0, 1'b0, 3'b000, 12'h000, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0};
    vecs[1]  = '{1'b1, 1'b1, 3'b001, 12'h003, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0};
    vecs[2]  = '{1'b1, 1'b1, 3'b001, 12'h003, 1'b1, 1'b1, 1'b0, 3'b001, 2'd0};
    vecs[3]  = '{1'b1, 1'b1, 3'b001, 12'h003, 1'b1, 1'b1, 1'b0, 3'b001, 2'd0};
    vecs[4]  = '{1'b1, 1'b1, 3'b001, 12'h003, 1'b1, 1'b1, 1'b0, 3'b001, 2'd0};
    vecs[5]  = '{1'b1, 1'b1, 3'b001, 12'h003, 1'b1, 1'b1, 1'b1, 3'b001, 2'd0};
    vecs[6]  = '{1'b1, 1'b1, 3'b000, 12'h003, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0};
    vecs[7]  = '{1'b1, 1'b1, 3'b010, 12'h020, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0};
    vecs[8]  = '{1'b1, 1'b1, 3'b010, 12'h020, 1'b1, 1'b1, 1'b0, 3'b010, 2'd1};
    vecs[9]  = '{1'b1, 1'b1, 3'b010, 12'h020, 1'b0, 1'b1, 1'b0, 3'b000, 2'd1};
    vecs[10] = '{1'b1, 1'b1, 3'b010, 12'h020, 1'b0, 1'b1, 1'b0, 3'b000, 2'd1};
    vecs[11] = '{1'b1, 1'b1, 3'b010, 12'h020, 1'b1, 1'b1, 1'b0, 3'b010, 2'd1};
    vecs[12] = '{1'b1, 1'b1, 3'b010, 12'h020, 1'b1, 1'b1, 1'b1, 3'b010, 2'd1};
    vecs[13] = '{1'b1, 1'b1, 3'b000, 12'h020, 1'b1, 1'b0, 1'b0, 3'b000, 2'd1};

    rstn = 1'b0; en = 1'b0; req_vld = '0; req_len = '0; req_data = 24'h332211; o_rdy = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven vectors.
    for (int v = 0; v < NV; v++) begin
      rstn = vecs[v].rstn; en = vecs[v].en; req_vld = vecs[v].vld;
      req_len = vecs[v].len; o_rdy = vecs[v].rdy;
      #2;
      check("tbl_ctl", 32'({o_vld, o_last, req_rdy, o_src}),
            32'({vecs[v].e_vld, vecs[v].e_last, vecs[v].e_rdy, vecs[v].e_src}));
      if (vecs[v].e_vld) check("tbl_data", 32'(o_data), 32'(req_data[vecs[v].e_src*DW +: DW]));
      sample_and_advance();
    end

    // Three 1-beat requesters after reset: grant order 0,1,2,0,1 with bubbles.
    rstn = 1'b0; tick();
    rstn = 1'b1; en = 1'b1; req_vld = 3'b111; req_len = 12'h000; o_rdy = 1'b1;
    log_q.delete();
    ticks(10);
    check_log("rr_order", 5, '{0, 1, 2, 0, 1, 0, 0, 0});
    req_vld = 3'b000; tick();

    // en gating: nothing while low; a running burst completes with en low.
    log_q.delete();
    en = 1'b0; req_vld = 3'b111; req_len = 12'h222;
    ticks(4);
    en = 1'b1; tick();
    en = 1'b0; ticks(6);
    en = 1'b1; ticks(4);
    req_vld = 3'b000; tick();
    check_log("en_gate", 6, '{2, 2, 2, 0, 0, 0, 0, 0});

    // Reset during beat 2 of a 6-beat burst from req2.
    en = 1'b1; req_vld = 3'b100; req_len = 12'h500;
    ticks(2);
    rstn = 1'b0; tick();
    rstn = 1'b1; req_vld = 3'b111; req_len = 12'h000;
    #2;
    check("rst_vld", 32'(o_vld), 32'd0);
    check("rst_rdy", 32'(req_rdy), 32'd0);
    sample_and_advance();
    #2;
    check("rst_winner", 32'({o_vld, o_src}), 32'({1'b1, 2'd0}));
    sample_and_advance();
    req_vld = 3'b000; tick();

    // Wrap: after req2 wins, req0 then req1.
    req_vld = 3'b100; ticks(2);
    req_vld = 3'b011; log_q.delete();
    ticks(4);
    req_vld = 3'b000; tick();
    check_log("wrap", 2, '{0, 1, 0, 0, 0, 0, 0, 0});

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      rstn     = ($urandom_range(63) != 0);
      en       = ($urandom_range(3) != 0);
      req_vld  = N'($urandom);
      o_rdy    = ($urandom_range(3) != 0);
      req_data = (N*DW)'($urandom);
      for (int i = 0; i < int'(N); i++)
        req_len[i*LENW +: LENW] = ($urandom_range(7) == 0) ? LENW'(15) : LENW'($urandom_range(3));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
